// File: rtl/sevseg_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : sevseg_scan_if
// Function : Display data in / multiplexed cathode+anode drive out bundle.
// Revision : 1.0
// ============================================================================
interface sevseg_scan_if #(
  parameter int NDIG = 8
);
  logic                 load;
  logic [4*NDIG-1:0]    value;
  logic [NDIG-1:0]      dp;
  logic [NDIG-1:0]      blank;
  logic [6:0]           seg;
  logic                 dp_n;
  logic [NDIG-1:0]      an;
  logic                 frame_tick;

  modport master (
    output load, value, dp, blank,
    input  seg, dp_n, an, frame_tick
  );

  modport slave (
    input  load, value, dp, blank,
    output seg, dp_n, an, frame_tick
  );
endinterface
`default_nettype wire

// File: rtl/sevseg_scan.sv
`default_nettype none
// ============================================================================
// Module   : sevseg_scan
// Function : Multiplexed 7-segment scanner with shadowed display data.
//            Optional macro SEVSEG_LZ_BLANK_EN enables leading-zero blanking.
// Revision : 1.0
// ============================================================================
module sevseg_scan #(
  parameter int NDIG = 8,
  parameter int DIV  = 100000
) (
  input logic          clk,
  input logic          rst,
  sevseg_scan_if.slave bus
);
  localparam int              CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int              IW       = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0]   IDX_LAST = IW'(NDIG - 1);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [4*NDIG-1:0]  value_q, value_d;
  logic [NDIG-1:0]    dp_q, dp_d;
  logic [NDIG-1:0]    blank_q, blank_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_n_q, dp_n_d;
  logic [NDIG-1:0]    an_q, an_d;
  logic               frame_tick_q, frame_tick_d;

  logic               step;
  logic [NDIG-1:0]    lz;
  logic [3:0]         nib;
  logic               sel_dp;
  logic               sel_dark;
`ifdef SEVSEG_LZ_BLANK_EN
  logic               lz_run;
`endif

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 7'b1000000;
      4'h1:    hex7 = 7'b1111001;
      4'h2:    hex7 = 7'b0100100;
      4'h3:    hex7 = 7'b0110000;
      4'h4:    hex7 = 7'b0011001;
      4'h5:    hex7 = 7'b0010010;
      4'h6:    hex7 = 7'b0000010;
      4'h7:    hex7 = 7'b1111000;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0010000;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b0000011;
      4'hC:    hex7 = 7'b1000110;
      4'hD:    hex7 = 7'b0100001;
      4'hE:    hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Leading-zero mask, walked from the most significant digit down; digit 0 never blanks.
  always_comb begin
    lz = '0;
`ifdef SEVSEG_LZ_BLANK_EN
    lz_run = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      lz_run = lz_run && (value_q[4*i +: 4] == 4'h0) && !dp_q[i];
      lz[i]  = lz_run;
    end
`endif
  end

  always_comb begin
    step         = (cnt_q == CNT_LAST);
    cnt_d        = step ? '0 : cnt_q + CW'(1);
    idx_d        = idx_q;
    if (step) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
    frame_tick_d = step && (idx_q == IDX_LAST);

    value_d = bus.load ? bus.value : value_q;
    dp_d    = bus.load ? bus.dp    : dp_q;
    blank_d = bus.load ? bus.blank : blank_q;

    // Outputs use pre-edge index and shadows, so a load on a step edge never mixes data.
    nib      = 4'h0;
    sel_dp   = 1'b0;
    sel_dark = 1'b1;
    an_d     = '1;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_q == IW'(i)) begin
        nib      = value_q[4*i +: 4];
        sel_dp   = dp_q[i];
        sel_dark = blank_q[i] | lz[i];
        an_d[i]  = blank_q[i] | lz[i];
      end
    end
    seg_d  = sel_dark ? 7'b1111111 : hex7(nib);
    dp_n_d = sel_dark | ~sel_dp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      value_q      <= '0;
      dp_q         <= '0;
      blank_q      <= '1;
      seg_q        <= 7'b1111111;
      dp_n_q       <= 1'b1;
      an_q         <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      value_q      <= value_d;
      dp_q         <= dp_d;
      blank_q      <= blank_d;
      seg_q        <= seg_d;
      dp_n_q       <= dp_n_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = frame_tick_q;
endmodule
`default_nettype wire

// File: tb/tb_sevseg_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_sevseg_scan
// Function : Self-checking bench for sevseg_scan (NDIG=4/DIV=4 and NDIG=1/DIV=2).
// Revision : 1.0
// ============================================================================
module tb_sevseg_scan;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sevseg_scan_if #(.NDIG(4)) bus0 ();
  sevseg_scan_if #(.NDIG(1)) bus1 ();

  sevseg_scan #(.NDIG(4), .DIV(4)) u0 (.clk(clk), .rst(rst), .bus(bus0));
  sevseg_scan #(.NDIG(1), .DIV(2)) u1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct packed {
    logic [6:0] seg;
    logic       dp_n;
    logic [7:0] an;
    logic       ft;
  } exp_t;

  localparam exp_t EXP_RST = '{seg: 7'b1111111, dp_n: 1'b1, an: 8'hFF, ft: 1'b0};
  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int n_vec = 0;
  int n_err = 0;
  int kcyc  = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Output after the (n+1)-th edge since reset: digit = floor(n/DIV) mod NDIG.
  function automatic exp_t model(input int ndig, input int div, input int n,
                                 input logic [31:0] val, input logic [7:0] dpv,
                                 input logic [7:0] blk);
    exp_t       m;
    int         d;
    logic       lzb;
    logic       dark;
    d   = (n / div) % ndig;
    lzb = 1'b0;
`ifdef SEVSEG_LZ_BLANK_EN
    if (d > 0) begin
      lzb = 1'b1;
      for (int j = d; j < ndig; j++)
        if (val[4*j +: 4] != 4'h0 || dpv[j]) lzb = 1'b0;
    end
`endif
    dark   = blk[d] | lzb;
    m.an   = 8'hFF;
    if (!dark) m.an[d] = 1'b0;
    m.seg  = dark ? 7'b1111111 : SEG_TAB[val[4*d +: 4]];
    m.dp_n = dark | ~dpv[d];
    m.ft   = ((n + 1) % (div * ndig)) == 0;
    return m;
  endfunction

  logic        mvalid = 1'b0;
  int          n0, n1;
  logic [31:0] sv0, sv1;
  logic [7:0]  sd0, sd1, sb0, sb1;
  exp_t        e0, e1;

  always @(posedge clk) begin
    if (rst) begin
      n0 = 0; sv0 = '0; sd0 = '0; sb0 = '1; e0 = EXP_RST;
      n1 = 0; sv1 = '0; sd1 = '0; sb1 = '1; e1 = EXP_RST;
      mvalid = 1'b1;
    end else begin
      e0 = model(4, 4, n0, sv0, sd0, sb0);
      e1 = model(1, 2, n1, sv1, sd1, sb1);
      if (bus0.load) begin
        sv0 = {16'h0, bus0.value}; sd0 = {4'h0, bus0.dp}; sb0 = {4'h0, bus0.blank};
      end
      if (bus1.load) begin
        sv1 = {28'h0, bus1.value}; sd1 = {7'h0, bus1.dp}; sb1 = {7'h0, bus1.blank};
      end
      n0++;
      n1++;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("u0.seg",        {1'b0, bus0.seg},        {1'b0, e0.seg});
      chk("u0.dp_n",       {7'h0, bus0.dp_n},       {7'h0, e0.dp_n});
      chk("u0.an",         {4'h0, bus0.an},         {4'h0, e0.an[3:0]});
      chk("u0.frame_tick", {7'h0, bus0.frame_tick}, {7'h0, e0.ft});
      chk("u1.seg",        {1'b0, bus1.seg},        {1'b0, e1.seg});
      chk("u1.dp_n",       {7'h0, bus1.dp_n},       {7'h0, e1.dp_n});
      chk("u1.an",         {7'h0, bus1.an},         {7'h0, e1.an[0]});
      chk("u1.frame_tick", {7'h0, bus1.frame_tick}, {7'h0, e1.ft});
    end
  end

  task automatic drive(input logic ld, input logic [15:0] v, input logic [3:0] d,
                       input logic [3:0] b);
    bus0.load = ld; bus0.value = v;      bus0.dp = d;    bus0.blank = b;
    bus1.load = ld; bus1.value = v[3:0]; bus1.dp = d[0]; bus1.blank = b[0];
  endtask

  task automatic go(input int k);
    while (kcyc < k) begin
      @(negedge clk);
      kcyc++;
    end
  endtask

  task automatic release_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    rst = 1'b0;
    drive(1'b1, v, d, b);
    @(negedge clk);
    kcyc = 1;
    drive(1'b0, v, d, b);
  endtask

  task automatic reset_and_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    rst = 1'b1;
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    repeat (3) @(negedge clk);
    release_load(v, d, b);
  endtask

  int nft;

  initial begin
    drive(1'b0, 16'h0, 4'h0, 4'h0);

    // Basic walk of 12AF and frame ticks
    reset_and_load(16'h12AF, 4'h0, 4'h0);
    chk("t1_unloaded_dark_an", {4'h0, bus0.an}, 8'b1111);
    go(2);
    chk("t1_d0_an",  {4'h0, bus0.an}, 8'b1110);
    chk("t1_d0_seg", {1'b0, bus0.seg}, {1'b0, 7'b0001110});
    chk("t1_u1_ft_k2", {7'h0, bus1.frame_tick}, 8'h1);
    chk("t1_u1_an_k2", {7'h0, bus1.an}, 8'h0);
    go(3);
    chk("t1_u1_ft_k3", {7'h0, bus1.frame_tick}, 8'h0);
    go(5);
    chk("t1_d1_an",  {4'h0, bus0.an}, 8'b1101);
    chk("t1_d1_seg", {1'b0, bus0.seg}, {1'b0, 7'b0001000});
    go(9);
    chk("t1_d2_an",  {4'h0, bus0.an}, 8'b1011);
    chk("t1_d2_seg", {1'b0, bus0.seg}, {1'b0, 7'b0100100});
    go(13);
    chk("t1_d3_an",  {4'h0, bus0.an}, 8'b0111);
    chk("t1_d3_seg", {1'b0, bus0.seg}, {1'b0, 7'b1111001});
    go(15);
    chk("t1_ft_k15", {7'h0, bus0.frame_tick}, 8'h0);
    go(16);
    chk("t1_ft_k16", {7'h0, bus0.frame_tick}, 8'h1);
    go(17);
    chk("t1_ft_k17", {7'h0, bus0.frame_tick}, 8'h0);
    chk("t1_wrap_an", {4'h0, bus0.an}, 8'b1110);
    go(32);
    chk("t1_ft_k32", {7'h0, bus0.frame_tick}, 8'h1);

    // All zeros with a decimal point on digit 2
    reset_and_load(16'h0000, 4'b0100, 4'h0);
    go(5);
    chk("t2_d1_seg",  {1'b0, bus0.seg}, {1'b0, 7'b1000000});
    chk("t2_d1_dpn",  {7'h0, bus0.dp_n}, 8'h1);
    go(9);
    chk("t2_d2_an",   {4'h0, bus0.an}, 8'b1011);
    chk("t2_d2_seg",  {1'b0, bus0.seg}, {1'b0, 7'b1000000});
    chk("t2_d2_dpn",  {7'h0, bus0.dp_n}, 8'h0);
    go(13);
`ifdef SEVSEG_LZ_BLANK_EN
    chk("t2_d3_an",   {4'h0, bus0.an}, 8'b1111);
    chk("t2_d3_seg",  {1'b0, bus0.seg}, {1'b0, 7'b1111111});
`else
    chk("t2_d3_an",   {4'h0, bus0.an}, 8'b0111);
    chk("t2_d3_seg",  {1'b0, bus0.seg}, {1'b0, 7'b1000000});
`endif

    // Load coincident with a step: 1111 -> 8888
    reset_and_load(16'h1111, 4'h0, 4'h0);
    go(3);
    drive(1'b1, 16'h8888, 4'h0, 4'h0);
    go(4);
    drive(1'b0, 16'h8888, 4'h0, 4'h0);
    chk("t3_old_d0_seg", {1'b0, bus0.seg}, {1'b0, 7'b1111001});
    go(5);
    chk("t3_new_d1_seg", {1'b0, bus0.seg}, {1'b0, 7'b0000000});
    chk("t3_new_d1_an",  {4'h0, bus0.an}, 8'b1101);

    // Forced blank overrides value and dp
    reset_and_load(16'h4321, 4'b0011, 4'b0010);
    go(2);
    chk("t4_d0_seg", {1'b0, bus0.seg}, {1'b0, 7'b1111001});
    chk("t4_d0_dpn", {7'h0, bus0.dp_n}, 8'h0);
    go(5);
    chk("t4_d1_an",  {4'h0, bus0.an}, 8'b1111);
    chk("t4_d1_seg", {1'b0, bus0.seg}, {1'b0, 7'b1111111});
    chk("t4_d1_dpn", {7'h0, bus0.dp_n}, 8'h1);

    // Reset during digit 2's slot aborts the frame
    reset_and_load(16'h12AF, 4'h0, 4'h0);
    go(10);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_an",  {4'h0, bus0.an}, 8'b1111);
    chk("t5_rst_seg", {1'b0, bus0.seg}, {1'b0, 7'b1111111});
    chk("t5_rst_ft",  {7'h0, bus0.frame_tick}, 8'h0);
    release_load(16'h12AF, 4'h0, 4'h0);
    nft = 0;
    for (int k = 2; k <= 15; k++) begin
      go(k);
      if (bus0.frame_tick) nft++;
      if (k == 4) chk("t5_d0_still_lit", {4'h0, bus0.an}, 8'b1110);
      if (k == 5) chk("t5_d1_next",      {4'h0, bus0.an}, 8'b1101);
    end
    chk("t5_no_early_tick", nft[7:0], 8'h0);
    go(16);
    chk("t5_first_tick", {7'h0, bus0.frame_tick}, 8'h1);

    // Load held high tracks inputs, load low holds
    reset_and_load(16'h0000, 4'h0, 4'h0);
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, 16'($urandom), 4'($urandom), 4'($urandom));
      @(negedge clk);
    end
    for (int i = 0; i < 24; i++) begin
      drive(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
      @(negedge clk);
    end

    // Reset wins over a coincident load
    rst = 1'b1;
    drive(1'b1, 16'h8888, 4'hF, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 16'h8888, 4'hF, 4'h0);
    repeat (2) @(negedge clk);
    chk("t7_rst_beats_load_an", {4'h0, bus0.an}, 8'b1111);
    repeat (6) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
